// File: rtl/mem_req_axi_master_if.sv
// AXI4 bus between mem_req_axi_master and its slave: AW, W, B, AR and R channels.
interface mem_req_axi_master_if #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_USER_WIDTH = 10
);
    logic [AXI_ID_WIDTH-1:0]   awid;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic [3:0]                awqos;
    logic [3:0]                awregion;
    logic [AXI_USER_WIDTH-1:0] awuser;
    logic                      awvalid;
    logic                      awready;

    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [AXI_STRB_WIDTH-1:0] wstrb;
    logic                      wlast;
    logic [AXI_USER_WIDTH-1:0] wuser;
    logic                      wvalid;
    logic                      wready;

    logic [AXI_ID_WIDTH-1:0]   bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [AXI_ID_WIDTH-1:0]   arid;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic [3:0]                arqos;
    logic [3:0]                arregion;
    logic [AXI_USER_WIDTH-1:0] aruser;
    logic                      arvalid;
    logic                      arready;

    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/mem_req_axi_master.sv
// Bridges a req/gnt/r_valid memory port to single-beat AXI4, one transaction outstanding.
// Latency: response 3 cycles after grant with AXI ready tied high; any AXI back-pressure only stalls.
module mem_req_axi_master #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_USER_WIDTH = 10,
    parameter int AXI_ID_VALUE   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      data_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] data_add_i,
    input  logic                      data_wen_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_wdata_i,
    input  logic [AXI_STRB_WIDTH-1:0] data_be_i,
    output logic                      data_gnt_o,
    output logic                      data_r_valid_o,
    output logic [AXI_DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                      data_err_o,
    mem_req_axi_master_if.master      axi
);
    localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_STRB_WIDTH));

    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

    state_t                    state, state_nxt;
    logic                      aw_done, aw_done_nxt;
    logic                      w_done, w_done_nxt;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [AXI_STRB_WIDTH-1:0] be_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_nxt;
    logic                      err_q, err_nxt;
    logic                      capture;
    logic                      gnt, awvalid, wvalid, bready, arvalid, rready, r_valid;
    logic                      unused_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            if (capture) begin
                addr_q  <= data_add_i;
                wdata_q <= data_wdata_i;
                be_q    <= data_be_i;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        rdata_nxt   = rdata_q;
        err_nxt     = err_q;
        capture     = 1'b0;
        gnt         = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        r_valid     = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so nothing is granted while the block is held in reset.
                gnt = data_req_i & ~reset;
                if (gnt) begin
                    capture     = 1'b1;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    state_nxt   = data_wen_i ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently; leave once both have handshaken.
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                if (awvalid && axi.awready) aw_done_nxt = 1'b1;
                if (wvalid && axi.wready)   w_done_nxt  = 1'b1;
                if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (axi.bvalid) begin
                    err_nxt   = axi.bresp[1];
                    rdata_nxt = '0;
                    state_nxt = RESP;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (axi.arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (axi.rvalid) begin
                    rdata_nxt = axi.rdata;
                    err_nxt   = axi.rresp[1];
                    state_nxt = RESP;
                end
            end
            RESP: begin
                r_valid   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign data_gnt_o     = gnt;
    assign data_r_valid_o = r_valid;
    assign data_r_rdata_o = rdata_q;
    assign data_err_o     = err_q;

    assign axi.awid     = AXI_ID_WIDTH'(AXI_ID_VALUE);
    assign axi.awaddr   = addr_q;
    assign axi.awlen    = 8'd0;
    assign axi.awsize   = AXI_SIZE;
    assign axi.awburst  = 2'b01;
    assign axi.awlock   = 1'b0;
    assign axi.awcache  = 4'd0;
    assign axi.awprot   = 3'd0;
    assign axi.awqos    = 4'd0;
    assign axi.awregion = 4'd0;
    assign axi.awuser   = '0;
    assign axi.awvalid  = awvalid;

    assign axi.wdata    = wdata_q;
    assign axi.wstrb    = be_q;
    assign axi.wlast    = 1'b1;
    assign axi.wuser    = '0;
    assign axi.wvalid   = wvalid;

    assign axi.bready   = bready;

    assign axi.arid     = AXI_ID_WIDTH'(AXI_ID_VALUE);
    assign axi.araddr   = addr_q;
    assign axi.arlen    = 8'd0;
    assign axi.arsize   = AXI_SIZE;
    assign axi.arburst  = 2'b01;
    assign axi.arlock   = 1'b0;
    assign axi.arcache  = 4'd0;
    assign axi.arprot   = 3'd0;
    assign axi.arqos    = 4'd0;
    assign axi.arregion = 4'd0;
    assign axi.aruser   = '0;
    assign axi.arvalid  = arvalid;

    assign axi.rready   = rready;

    // IDs, rlast and the low response bits are deliberately not inspected.
    assign unused_ok = ^{axi.bid, axi.rid, axi.rlast, axi.bresp[0], axi.rresp[0]};
endmodule

// File: tb/tb_mem_req_axi_master.sv
// Bench for mem_req_axi_master: delay-programmable AXI slave, bus monitor and response scoreboard.
module tb_mem_req_axi_master;
    localparam int IW = 1, DW = 32, SW = 4, AW = 32, UW = 10;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          data_req_i, data_wen_i;
    logic [31:0]   data_add_i, data_wdata_i;
    logic [3:0]    data_be_i;
    logic          data_gnt_o, data_r_valid_o, data_err_o;
    logic [31:0]   data_r_rdata_o;

    mem_req_axi_master_if #(.AXI_ID_WIDTH(IW), .AXI_DATA_WIDTH(DW), .AXI_STRB_WIDTH(SW),
                            .AXI_ADDR_WIDTH(AW), .AXI_USER_WIDTH(UW)) axi ();

    mem_req_axi_master #(.AXI_ID_WIDTH(IW), .AXI_DATA_WIDTH(DW), .AXI_STRB_WIDTH(SW),
                         .AXI_ADDR_WIDTH(AW), .AXI_USER_WIDTH(UW), .AXI_ID_VALUE(0)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_wen_i     (data_wen_i),
        .data_wdata_i   (data_wdata_i),
        .data_be_i      (data_be_i),
        .data_gnt_o     (data_gnt_o),
        .data_r_valid_o (data_r_valid_o),
        .data_r_rdata_o (data_r_rdata_o),
        .data_err_o     (data_err_o),
        .axi            (axi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
    logic [31:0] rdata_v = 32'h0;

    // Expectations for the monitor
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    resp_t       sb_q[$];

    // Monitor records (cycles relative to the last grant)
    int cyc = 0, tick = 0, valid_tick = -100, gnt_cnt = 0, gnt_gap = 0, proto_err = 0;
    int aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c, bready_c, valid_c, valid_n;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_valid;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    resp_t       mon_e;

    // AXI slave: each ready/valid rises after its programmed number of waiting cycles
    initial begin
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = 2'b00;
        axi.rvalid = 1'b0; axi.rid = '0; axi.rresp = 2'b00; axi.rdata = '0; axi.rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (axi.awvalid) begin axi.awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin axi.awready = 1'b0; aw_cnt = 0; end
            if (axi.wvalid) begin axi.wready = (w_cnt >= w_dly); w_cnt++; end
            else begin axi.wready = 1'b0; w_cnt = 0; end
            if (axi.arvalid) begin axi.arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin axi.arready = 1'b0; ar_cnt = 0; end
            if (axi.bready) begin axi.bvalid = (b_cnt >= b_dly); axi.bresp = bresp_v; b_cnt++; end
            else begin axi.bvalid = 1'b0; b_cnt = 0; end
            if (axi.rready) begin
                axi.rvalid = (r_cnt >= r_dly); axi.rdata = rdata_v; axi.rresp = rresp_v; axi.rlast = 1'b1; r_cnt++;
            end else begin
                axi.rvalid = 1'b0; axi.rdata = 32'hBAD0BAD0; r_cnt = 0;
            end
        end
    end

    // Monitor: samples just before each rising edge
    initial begin
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_valid = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
        forever begin
            @(negedge clk);
            #4;
            tick++;
            if (reset) begin
                p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_valid = 0;
                continue;
            end
            if (data_gnt_o) begin
                cyc = 0; gnt_cnt++; gnt_gap = tick - valid_tick;
                aw_hs_c = -1; w_hs_c = -1; b_hs_c = -1; ar_hs_c = -1; r_hs_c = -1;
                bready_c = -1; valid_c = -1; valid_n = 0;
            end else begin
                cyc++;
            end
            if (axi.awvalid && axi.awready) begin
                aw_hs_c = cyc;
                check("awaddr", axi.awaddr, exp_addr);
                check("aw_beat", {axi.awid, axi.awlen, axi.awsize, axi.awburst}, {1'b0, 8'd0, 3'd2, 2'b01});
                check("aw_side", {axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion, axi.awuser, axi.wuser}, 0);
            end
            if (axi.wvalid && axi.wready) begin
                w_hs_c = cyc;
                check("wdata", axi.wdata, exp_wdata);
                check("wstrb", axi.wstrb, exp_be);
                check("wlast", axi.wlast, 1);
            end
            if (axi.bready && bready_c < 0) bready_c = cyc;
            if (axi.bready && axi.bvalid) b_hs_c = cyc;
            if (axi.arvalid && axi.arready) begin
                ar_hs_c = cyc;
                check("araddr", axi.araddr, exp_addr);
                check("ar_beat", {axi.arid, axi.arlen, axi.arsize, axi.arburst}, {1'b0, 8'd0, 3'd2, 2'b01});
                check("ar_side", {axi.arlock, axi.arcache, axi.arprot, axi.arqos, axi.arregion, axi.aruser}, 0);
            end
            if (axi.rready && axi.rvalid) r_hs_c = cyc;
            if (data_r_valid_o) begin
                valid_c = cyc; valid_n++; valid_tick = tick;
                check("resp_expected", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("rdata", data_r_rdata_o, mon_e.rdata);
                    check("err", data_err_o, mon_e.err);
                end
            end
            // Stall rules: held valids keep payload, completed valids drop, response is a single pulse
            if (p_awv && !p_awr && (!axi.awvalid || axi.awaddr !== p_awaddr)) proto_err++;
            if (p_awv && p_awr && axi.awvalid) proto_err++;
            if (p_wv && !p_wr && (!axi.wvalid || axi.wdata !== p_wdata || axi.wstrb !== p_wstrb)) proto_err++;
            if (p_wv && p_wr && axi.wvalid) proto_err++;
            if (p_arv && !p_arr && (!axi.arvalid || axi.araddr !== p_araddr)) proto_err++;
            if (p_arv && p_arr && axi.arvalid) proto_err++;
            if (p_valid && data_r_valid_o) proto_err++;
            p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
            p_wv = axi.wvalid; p_wr = axi.wready; p_wdata = axi.wdata; p_wstrb = axi.wstrb;
            p_arv = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
            p_valid = data_r_valid_o;
        end
    end

    task automatic push_exp(input logic [31:0] rd, input logic er);
        resp_t r;
        r.rdata = rd;
        r.err   = er;
        sb_q.push_back(r);
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_er);
        bit got;
        got = 0;
        @(negedge clk);
        data_req_i = 1'b1; data_wen_i = wen; data_add_i = addr; data_wdata_i = wdata; data_be_i = be;
        exp_addr = addr; exp_wdata = wdata; exp_be = be;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (data_gnt_o) begin got = 1; break; end
            @(negedge clk);
        end
        check("grant_seen", got, 1);
        if (got) push_exp(exp_rd, exp_er);
        @(negedge clk);
        data_req_i = 1'b0; data_wen_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin ok = 1; break; end
        end
        check(tag, ok, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int g0;
        reset = 1'b1;
        data_req_i = 1'b1; data_wen_i = 1'b0; data_add_i = '0; data_wdata_i = '0; data_be_i = '0;
        exp_addr = '0; exp_wdata = '0; exp_be = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", data_gnt_o, 0);
        check("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, data_r_valid_o}, 0);
        check("rst_resp", {data_r_rdata_o, data_err_o}, 0);
        data_req_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Write, all readys high
        issue(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        wait_done("t1_done");
        check("t1_aw_cyc", aw_hs_c, 1);
        check("t1_w_cyc", w_hs_c, 1);
        check("t1_b_cyc", b_hs_c, 2);
        check("t1_valid_cyc", valid_c, 3);
        check("t1_valid_n", valid_n, 1);

        // Read with delayed arready and rvalid
        ar_dly = 4; r_dly = 3; rdata_v = 32'h12345678;
        issue(1'b0, 32'h100, 32'h0, 4'hF, 32'h12345678, 1'b0);
        wait_done("t2_done");
        check("t2_ar_cyc", ar_hs_c, 5);
        check("t2_r_cyc", r_hs_c, 9);
        check("t2_valid_cyc", valid_c, 10);
        check("t2_valid_n", valid_n, 1);
        check("t2_rdata_hold", data_r_rdata_o, 32'h12345678);
        check("t2_proto", proto_err, 0);

        // Skewed write: W accepted at once, AW late
        ar_dly = 0; r_dly = 0; aw_dly = 4;
        issue(1'b1, 32'h80, 32'hCAFEF00D, 4'h3, 32'h0, 1'b0);
        wait_done("t3_done");
        check("t3_w_cyc", w_hs_c, 1);
        check("t3_aw_cyc", aw_hs_c, 5);
        check("t3_bready_cyc", bready_c, 6);
        check("t3_valid_cyc", valid_c, 7);
        check("t3_proto", proto_err, 0);

        // Error response, then a clean read
        aw_dly = 0; bresp_v = 2'b10;
        issue(1'b1, 32'hC0, 32'h11112222, 4'hF, 32'h0, 1'b1);
        wait_done("t4_done");
        check("t4_err_hold", data_err_o, 1);
        bresp_v = 2'b00; rdata_v = 32'hA5A50001;
        issue(1'b0, 32'hC4, 32'h0, 4'hF, 32'hA5A50001, 1'b0);
        wait_done("t4b_done");
        check("t4_err_clear", data_err_o, 0);

        // Request held high across a read
        rdata_v = 32'h0BADF00D;
        g0 = gnt_cnt;
        @(negedge clk);
        data_req_i = 1'b1; data_wen_i = 1'b0; data_add_i = 32'h200; data_be_i = 4'hF;
        exp_addr = 32'h200;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (data_gnt_o) begin got = 1; break; end
            @(negedge clk);
        end
        check("t5_grant1", got, 1);
        if (got) push_exp(32'h0BADF00D, 1'b0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (data_gnt_o) begin got = 1; break; end
        end
        check("t5_grant2", got, 1);
        if (got) push_exp(32'h0BADF00D, 1'b0);
        @(negedge clk);
        data_req_i = 1'b0;
        wait_done("t5_done");
        check("t5_grants", gnt_cnt - g0, 2);
        check("t5_gap", gnt_gap, 1);

        // Reset while waiting in RD_DATA
        r_dly = 50; rdata_v = 32'h55AA55AA;
        issue(1'b0, 32'h300, 32'h0, 4'hF, 32'h55AA55AA, 1'b0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (axi.rready) begin got = 1; break; end
        end
        check("t6_in_rd_data", got, 1);
        reset = 1'b1;
        sb_q.delete();
        #1;
        check("t6_rst_ready", {axi.rready, axi.arvalid, data_r_valid_o}, 0);
        check("t6_rst_resp", {data_r_rdata_o, data_err_o}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        r_dly = 0; rdata_v = 32'h600D600D;
        issue(1'b0, 32'h304, 32'h0, 4'hF, 32'h600D600D, 1'b0);
        wait_done("t6_done");
        check("t6_valid_cyc", valid_c, 3);
        check("t6_proto", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
